// File: rtl/serial_chk_pkg.sv
// serial_chk_pkg: shared lane state type and sizing helpers for the serial word checker
package serial_chk_pkg;
  typedef enum logic {IDLE, SHIFT} lane_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/serial_chk_lane.sv
// serial_chk_lane: one serial lane -- deframer, range check, pulse outputs, saturating counters
module serial_chk_lane
  import serial_chk_pkg::*;
#(
  parameter int WORD_W  = 4,
  parameter int MAX_VAL = 9,
  parameter int FRAMED  = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             line,
  output logic             u,
  output logic             e,
  output logic [CNT_W-1:0] hit,
  output logic [CNT_W-1:0] err
);
  localparam int BW = clog2(WORD_W);
  localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);
  localparam logic [WORD_W-1:0] MAXW = WORD_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));
  localparam lane_state_t RST_ST = FRAMED != 0 ? IDLE : SHIFT;
  lane_state_t state, state_n;
  logic [WORD_W-2:0] sh, sh_n;
  logic [BW-1:0] cnt, cnt_n;
  logic [WORD_W-1:0] word;
  logic shifting, fire, u_n, e_n;
  logic [CNT_W-1:0] hit_n, err_n;
  // next state: clr overrides everything, en=0 freezes the lane, pulses only live one cycle
  always_comb begin
    shifting = en && state == SHIFT;
    fire     = shifting && cnt == LAST;
    word     = {sh, line};
    state_n  = clr ? RST_ST : (en && state == IDLE && line) ? SHIFT : (fire && FRAMED != 0) ? IDLE : state;
    sh_n     = clr ? '0 : shifting ? word[WORD_W-2:0] : sh;
    cnt_n    = (clr || fire) ? '0 : shifting ? cnt + BW'(1) : cnt;
    u_n      = !clr && fire && word <= MAXW;
    e_n      = !clr && fire && word > MAXW;
    hit_n    = clr ? '0 : (u_n && hit != CMAX) ? hit + CNT_W'(1) : hit;
    err_n    = clr ? '0 : (e_n && err != CMAX) ? err + CNT_W'(1) : err;
  end
  // lane registers; reset drops any partial word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_ST;
      sh    <= '0;
      cnt   <= '0;
      u     <= 1'b0;
      e     <= 1'b0;
      hit   <= '0;
      err   <= '0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      u     <= u_n;
      e     <= e_n;
      hit   <= hit_n;
      err   <= err_n;
    end
  end
endmodule

// File: rtl/serial_word_checker.sv
// serial_word_checker: NCH independent serial word range checkers with per-lane counters
module serial_word_checker
  import serial_chk_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int WORD_W  = 4,
  parameter int MAX_VAL = 9,
  parameter int FRAMED  = 0,
  parameter int CNT_W   = 8
) (
  input  logic                 clock,
  input  logic                 RESET_G,
  input  logic                 en,
  input  logic                 clr,
  input  logic [NCH-1:0]       LINEA,
  output logic [NCH-1:0]       U_REG,
  output logic [NCH-1:0]       ERR_REG,
  output logic [NCH*CNT_W-1:0] hit_cnt,
  output logic [NCH*CNT_W-1:0] err_cnt
);
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    serial_chk_lane #(
      .WORD_W (WORD_W),
      .MAX_VAL(MAX_VAL),
      .FRAMED (FRAMED),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk (clock),
      .rst (RESET_G),
      .en  (en),
      .clr (clr),
      .line(LINEA[i]),
      .u   (U_REG[i]),
      .e   (ERR_REG[i]),
      .hit (hit_cnt[i*CNT_W +: CNT_W]),
      .err (err_cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule
